serial_pattern_detector: RTL

Parametrised, runtime-configurable serial bit-pattern detector. It is the successor to the fixed "101" Moore sequence detector. It samples a qualified serial bit stream and compares the most recent `len` bits against a loadable pattern. Overlapping or non-overlapping matching is selectable. It emits a one-cycle registered match pulse and keeps a saturating match counter. It sits after serial receivers and before framing and sync logic. Its reset configuration reproduces the legacy 101 overlap detector.

---
 rtl/serial_pattern_detector.sv | 96 +++++++++
 1 files changed

// File: rtl/serial_pattern_detector.sv
// Serial bit-pattern detector: compares the most recent len_r accepted bits
// against a loadable pattern, emits a registered match pulse and counts matches.
module serial_pattern_detector #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    // Handshake: a bit is taken on every rising edge where in_valid=1 and
    // cfg_load=0; there is no ready, the block never stalls the source.

    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;
    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;

    logic             accept;
    logic [PAT_W-1:0] hist_next;
    logic [LEN_W-1:0] fill_next;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] len_load;
    logic             hit;

    assign accept    = in_valid && !cfg_load;
    assign hist_next = {hist[PAT_W-2:0], in};
    assign fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);

    // Only the low len_r bits take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (LEN_W'(i) < len_r);
        end
    end

    always_comb begin
        len_load = cfg_len;
        if (cfg_len == '0) begin
            len_load = LEN_W'(1);
        end else if (cfg_len > LEN_W'(PAT_W)) begin
            len_load = LEN_W'(PAT_W);
        end
    end

    assign hit = accept && (fill_next >= len_r) &&
                 (((hist_next ^ pat_r) & len_mask) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r <= PAT_W'(3'b101);
            len_r <= LEN_W'(3);
            ovl_r <= 1'b1;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (cfg_load) begin
            pat_r <= cfg_pattern;
            len_r <= len_load;
            ovl_r <= cfg_overlap;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (accept) begin
                hist <= hist_next;
                // Non-overlap mode restarts the fill so the next match needs len_r new bits.
                fill <= (hit && !ovl_r) ? '0 : fill_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
        end else if (cnt_clr) begin
            match_count <= hit ? CNT_W'(1) : '0;
        end else if (hit && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

endmodule
